lcd_bus_resp: RTL and testbench

LCD_BUS_RESP -- requirements
Module: lcd_bus_resp

---
 rtl/lcd_pkg.sv | 62 ++++++
 rtl/lcd_bus_resp_if.sv | 22 ++
 rtl/lcd_ddram.sv | 34 +++
 rtl/lcd_bus_resp.sv | 159 +++++++++++++++
 tb/tb_lcd_bus_resp.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus model: command opcodes,
// FSM encoding, address-counter wrap bounds and AC helper functions.
package lcd_pkg;

    // Command opcodes also used by the LCD writer
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0F;
    localparam logic [7:0] CMD_FUNC_SET  = 8'h38;
    localparam logic [7:0] CMD_SET_L0    = 8'h80;
    localparam logic [7:0] CMD_SET_L1    = 8'hC0;

    // Address-counter wrap bounds for the two display lines
    localparam logic [6:0] AC_L0_FIRST = 7'h00;
    localparam logic [6:0] AC_L0_LAST  = 7'h27;
    localparam logic [6:0] AC_L1_FIRST = 7'h40;
    localparam logic [6:0] AC_L1_LAST  = 7'h67;

    // Value of an empty character cell
    localparam logic [7:0] CHAR_BLANK = 8'h20;

    typedef enum logic [1:0] {
        LCD_IDLE  = 2'd0,
        LCD_EXEC  = 2'd1,
        LCD_CLEAR = 2'd2,
        LCD_BUSY  = 2'd3
    } lcd_state_e;

    // Internal state exposed for observation
    typedef struct packed {
        lcd_state_e state;
        logic       id;
        logic       s;
        logic [4:0] func;
        logic [4:0] clr_idx;
    } lcd_dbg_t;

    // Step the address counter with the line-to-line wrap rules
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (ac == AC_L0_LAST)      nxt = AC_L1_FIRST;
            else if (ac == AC_L1_LAST) nxt = AC_L0_FIRST;
            else                       nxt = ac + 7'd1;
        end else begin
            if (ac == AC_L1_FIRST)     nxt = AC_L0_LAST;
            else if (ac == AC_L0_FIRST) nxt = AC_L1_LAST;
            else                       nxt = ac - 7'd1;
        end
        return nxt;
    endfunction

    // Only the first 16 cells of each line are backed by storage
    function automatic logic ac_mapped(input logic [6:0] ac);
        return (ac[6:4] == 3'b000) || (ac[6:4] == 3'b100);
    endfunction

    function automatic logic [4:0] ac_index(input logic [6:0] ac);
        return {ac[6], ac[3:0]};
    endfunction

endpackage

// File: rtl/lcd_bus_resp_if.sv
// Parallel LCD bus between a bus master (LCD writer) and the responder.
// Protocol: the master holds RS/RWF/DATA stable while EN is high; a transfer
// completes on the falling edge of EN. During a read (RWF=1, EN=1) the
// responder drives O_LCD_DATA and raises O_LCD_OE; otherwise OE is low.
interface lcd_bus_resp_if;
    logic       I_LCD_EN;
    logic       I_LCD_RS;
    logic       I_LCD_RWF;
    logic [7:0] I_LCD_DATA;
    logic [7:0] O_LCD_DATA;
    logic       O_LCD_OE;

    modport master (
        output I_LCD_EN, I_LCD_RS, I_LCD_RWF, I_LCD_DATA,
        input  O_LCD_DATA, O_LCD_OE
    );

    modport slave (
        input  I_LCD_EN, I_LCD_RS, I_LCD_RWF, I_LCD_DATA,
        output O_LCD_DATA, O_LCD_OE
    );
endinterface

// File: rtl/lcd_ddram.sv
// 32x8 display RAM: one write port, one sweep-clear port, two async reads.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       I_CLK,
    input  logic       I_RSTF,
    input  logic       i_we,
    input  logic [4:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic       i_clr,
    input  logic [4:0] i_clr_addr,
    input  logic [4:0] i_raddr_a,
    output logic [7:0] o_rdata_a,
    input  logic [4:0] i_raddr_b,
    output logic [7:0] o_rdata_b
);

    logic [7:0] r_mem [32];

    // Reset blanks every cell; clear sweep takes priority over a data write
    always_ff @(posedge I_CLK) begin
        if (!I_RSTF) begin
            for (int i = 0; i < 32; i++) r_mem[i] <= CHAR_BLANK;
        end else if (i_clr) begin
            r_mem[i_clr_addr] <= CHAR_BLANK;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/lcd_bus_resp.sv
// Responder side of a character-LCD bus: decodes commands and data writes,
// models the busy flag, address counter and DDRAM, and answers reads.
module lcd_bus_resp
    import lcd_pkg::*;
#(
    parameter int BUSY_CYC = 4000,
    parameter int CLR_CYC  = 82000
) (
    input  logic          I_CLK,
    input  logic          I_RSTF,
    lcd_bus_resp_if.slave io_bus,
    input  logic [4:0]    I_RD_ADDR,
    output logic [7:0]    O_RD_DATA,
    output logic          O_BUSY,
    output logic [6:0]    O_AC,
    output logic [2:0]    O_DISP_CTRL,
    output logic          O_VIOL,
    output lcd_dbg_t      O_DBG
);

    localparam logic [1:0] S_IDLE  = LCD_IDLE;
    localparam logic [1:0] S_EXEC  = LCD_EXEC;
    localparam logic [1:0] S_CLEAR = LCD_CLEAR;
    localparam logic [1:0] S_BUSY  = LCD_BUSY;

    localparam int MAX_CYC = (CLR_CYC > BUSY_CYC) ? CLR_CYC : BUSY_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(CLR_CYC - 1);

    logic             r_en, r_rs, r_rwf, r_en_d, r_rs_d, r_rwf_d;
    logic [7:0]       r_data, r_data_d;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_ac;
    logic             r_id, r_s, r_viol, r_cmd_rs;
    logic [2:0]       r_dcb;
    logic [4:0]       r_func, r_clr_idx;
    logic [7:0]       r_cmd_data;

    logic       w_fall, w_wr_edge, w_rd_edge, w_accept, w_busy, w_we;
    logic [7:0] w_ac_data;

    // Single input register stage plus one delayed copy for edge detection
    always_ff @(posedge I_CLK) begin
        if (!I_RSTF) begin
            r_en <= 1'b0; r_rs <= 1'b0; r_rwf <= 1'b0; r_data <= 8'h00;
            r_en_d <= 1'b0; r_rs_d <= 1'b0; r_rwf_d <= 1'b0; r_data_d <= 8'h00;
        end else begin
            r_en <= io_bus.I_LCD_EN; r_rs <= io_bus.I_LCD_RS;
            r_rwf <= io_bus.I_LCD_RWF; r_data <= io_bus.I_LCD_DATA;
            r_en_d <= r_en; r_rs_d <= r_rs; r_rwf_d <= r_rwf; r_data_d <= r_data;
        end
    end

    assign w_fall    = r_en_d & ~r_en;
    assign w_wr_edge = w_fall & ~r_rwf_d;
    assign w_rd_edge = w_fall & r_rwf_d;
    assign w_busy    = (r_state != S_IDLE);
    // An edge in the cycle BUSY expires sees the post-transition IDLE state
    assign w_accept  = w_wr_edge & ((r_state == S_IDLE) ||
                                    ((r_state == S_BUSY) && (r_cnt == '0)));
    assign w_we      = (r_state == S_EXEC) & r_cmd_rs & ac_mapped(r_ac);

    // Controller FSM, address counter, mode latches and busy counter
    always_ff @(posedge I_CLK) begin
        if (!I_RSTF) begin
            r_state <= S_IDLE; r_cnt <= '0; r_ac <= 7'h00; r_id <= 1'b1;
            r_s <= 1'b0; r_dcb <= 3'b000; r_func <= 5'h00; r_clr_idx <= 5'd0;
            r_viol <= 1'b0; r_cmd_rs <= 1'b0; r_cmd_data <= 8'h00;
        end else begin
            r_viol <= w_wr_edge & ~w_accept;
            if (w_rd_edge && r_rs_d) r_ac <= ac_step(r_ac, r_id);
            if (w_accept) begin
                r_state    <= S_EXEC;
                r_cmd_rs   <= r_rs_d;
                r_cmd_data <= r_data_d;
            end
            case (r_state)
                S_EXEC: begin
                    r_state <= S_BUSY;
                    r_cnt   <= BUSY_LOAD;
                    if (r_cmd_rs) begin
                        r_ac <= ac_step(r_ac, r_id);
                    end else begin
                        casez (r_cmd_data)
                            8'b1???????: r_ac <= r_cmd_data[6:0];
                            8'b001?????: r_func <= r_cmd_data[4:0];
                            8'b0001????: if (!r_cmd_data[3]) r_ac <= ac_step(r_ac, r_cmd_data[2]);
                            8'b00001???: r_dcb <= r_cmd_data[2:0];
                            8'b000001??: begin r_id <= r_cmd_data[1]; r_s <= r_cmd_data[0]; end
                            8'b0000001?: r_ac <= 7'h00;
                            8'b00000001: begin
                                r_state   <= S_CLEAR;
                                r_cnt     <= CLR_LOAD;
                                r_clr_idx <= 5'd0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CLEAR: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                    r_clr_idx <= r_clr_idx + 5'd1;
                    if (r_clr_idx == 5'd31) begin
                        r_state <= S_BUSY;
                        r_ac    <= 7'h00;
                        r_id    <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                    else if (!w_accept) r_state <= S_IDLE;
                end
                default: ;
            endcase
        end
    end

    lcd_ddram u_ddram (
        .I_CLK      (I_CLK),
        .I_RSTF     (I_RSTF),
        .i_we       (w_we),
        .i_waddr    (ac_index(r_ac)),
        .i_wdata    (r_cmd_data),
        .i_clr      (r_state == S_CLEAR),
        .i_clr_addr (r_clr_idx),
        .i_raddr_a  (I_RD_ADDR),
        .o_rdata_a  (O_RD_DATA),
        .i_raddr_b  (ac_index(r_ac)),
        .o_rdata_b  (w_ac_data)
    );

    // Read-back mux driven while the registered strobe shows a read
    always_comb begin
        io_bus.O_LCD_OE   = 1'b0;
        io_bus.O_LCD_DATA = 8'h00;
        if (r_en && r_rwf) begin
            io_bus.O_LCD_OE = 1'b1;
            if (r_rs) io_bus.O_LCD_DATA = ac_mapped(r_ac) ? w_ac_data : CHAR_BLANK;
            else      io_bus.O_LCD_DATA = {w_busy, r_ac};
        end
    end

    // Debug view of internal state
    always_comb begin
        O_DBG.state   = lcd_state_e'(r_state);
        O_DBG.id      = r_id;
        O_DBG.s       = r_s;
        O_DBG.func    = r_func;
        O_DBG.clr_idx = r_clr_idx;
    end

    assign O_BUSY      = w_busy;
    assign O_AC        = r_ac;
    assign O_DISP_CTRL = r_dcb;
    assign O_VIOL      = r_viol;

endmodule

// File: tb/tb_lcd_bus_resp.sv
// Directed bench for lcd_bus_resp with shortened busy timings.
module tb_lcd_bus_resp;
    import lcd_pkg::*;

    localparam int BUSY_CYC = 40;
    localparam int CLR_CYC  = 100;

    logic       I_CLK = 1'b0;
    logic       I_RSTF;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy, viol;
    logic [6:0] ac;
    logic [2:0] disp;
    lcd_dbg_t   dbg;

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int viol_cnt = 0;
    logic [7:0] exp_q[$];

    lcd_bus_resp_if bus_if();

    lcd_bus_resp #(.BUSY_CYC(BUSY_CYC), .CLR_CYC(CLR_CYC)) dut (
        .I_CLK(I_CLK), .I_RSTF(I_RSTF), .io_bus(bus_if),
        .I_RD_ADDR(rd_addr), .O_RD_DATA(rd_data), .O_BUSY(busy), .O_AC(ac),
        .O_DISP_CTRL(disp), .O_VIOL(viol), .O_DBG(dbg)
    );

    // clock / reset
    always #5 I_CLK = ~I_CLK;

    always @(negedge I_CLK) if (viol === 1'b1) viol_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge I_CLK);
        #1;
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] d);
        @(posedge I_CLK); #1;
        bus_if.I_LCD_EN = 1'b1; bus_if.I_LCD_RS = rs;
        bus_if.I_LCD_RWF = 1'b0; bus_if.I_LCD_DATA = d;
        @(posedge I_CLK); #1;
        bus_if.I_LCD_EN = 1'b0;
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] d, output logic oe);
        @(posedge I_CLK); #1;
        bus_if.I_LCD_EN = 1'b1; bus_if.I_LCD_RS = rs; bus_if.I_LCD_RWF = 1'b1;
        @(posedge I_CLK); #1;
        d = bus_if.O_LCD_DATA; oe = bus_if.O_LCD_OE;
        bus_if.I_LCD_EN = 1'b0;
        tick(3);
        bus_if.I_LCD_RWF = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        tick(3);
        while (busy === 1'b1 && n < CLR_CYC + BUSY_CYC + 50) begin
            tick(1); n++;
        end
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s busy_timeout: got %b want 0", tag, busy);
        end
    endtask

    task automatic cmd(input logic [7:0] c);
        bus_write(1'b0, c);
        wait_idle($sformatf("cmd_%02h", c));
    endtask

    task automatic wdat(input logic [7:0] d);
        bus_write(1'b1, d);
        wait_idle($sformatf("data_%02h", d));
    endtask

    task automatic rd_cell(input int idx, output logic [7:0] d);
        rd_addr = 5'(idx);
        #1;
        d = rd_data;
    endtask

    // tests
    task automatic test_reset;
        logic [7:0] c;
        I_RSTF = 1'b0;
        tick(3);
        I_RSTF = 1'b1;
        tick(1);
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b want 0", busy); end
        vec_cnt++; if (ac !== 7'h00) begin err_cnt++; $display("FAIL rst_ac: got %h want 00", ac); end
        vec_cnt++; if (disp !== 3'b000) begin err_cnt++; $display("FAIL rst_disp: got %b want 000", disp); end
        vec_cnt++; if (viol !== 1'b0) begin err_cnt++; $display("FAIL rst_viol: got %b want 0", viol); end
        vec_cnt++; if (bus_if.O_LCD_OE !== 1'b0 || bus_if.O_LCD_DATA !== 8'h00) begin
            err_cnt++; $display("FAIL rst_bus: got oe=%b data=%h want 0/00", bus_if.O_LCD_OE, bus_if.O_LCD_DATA); end
        vec_cnt++; if (dbg.state !== LCD_IDLE || dbg.id !== 1'b1) begin
            err_cnt++; $display("FAIL rst_fsm: got state=%0d id=%b want 0/1", dbg.state, dbg.id); end
        rd_cell(31, c);
        vec_cnt++; if (c !== 8'h20) begin err_cnt++; $display("FAIL rst_ddram31: got %h want 20", c); end
    endtask

    task automatic test_init;
        logic [7:0] seq [7];
        logic [7:0] c;
        seq = '{CMD_FUNC_SET, CMD_FUNC_SET, CMD_FUNC_SET, CMD_FUNC_SET,
                CMD_DISP_ON, CMD_CLEAR, CMD_ENTRY_INC};
        for (int i = 0; i < 7; i++) begin
            cmd(seq[i]);
            tick(CLR_CYC + 5);
        end
        vec_cnt++; if (disp !== 3'b111) begin err_cnt++; $display("FAIL init_disp: got %b want 111", disp); end
        vec_cnt++; if (ac !== 7'h00) begin err_cnt++; $display("FAIL init_ac: got %h want 00", ac); end
        vec_cnt++; if (dbg.func !== 5'h18 || dbg.id !== 1'b1) begin
            err_cnt++; $display("FAIL init_mode: got func=%h id=%b want 18/1", dbg.func, dbg.id); end
        for (int i = 0; i < 32; i++) begin
            rd_cell(i, c);
            vec_cnt++; if (c !== 8'h20) begin err_cnt++; $display("FAIL init_cell%0d: got %h want 20", i, c); end
        end
        vec_cnt++; if (viol_cnt !== 0) begin err_cnt++; $display("FAIL init_viol: got %0d want 0", viol_cnt); end
    endtask

    task automatic test_hello;
        string l0 = "HELLO WORLD 1234";
        string l1 = "LINE TWO ABCDEFG";
        logic [7:0] c, exp;
        logic oe;
        cmd(CMD_SET_L0);
        for (int i = 0; i < 16; i++) begin wdat(l0[i]); exp_q.push_back(l0[i]); end
        vec_cnt++; if (ac !== 7'h10) begin err_cnt++; $display("FAIL hello_ac_l0: got %h want 10", ac); end
        cmd(CMD_SET_L1);
        for (int i = 0; i < 16; i++) begin wdat(l1[i]); exp_q.push_back(l1[i]); end
        vec_cnt++; if (ac !== 7'h50) begin err_cnt++; $display("FAIL hello_ac_l1: got %h want 50", ac); end
        for (int i = 0; i < 32; i++) begin
            exp = exp_q.pop_front();
            rd_cell(i, c);
            vec_cnt++; if (c !== exp) begin err_cnt++; $display("FAIL hello_cell%0d: got %h want %h", i, c, exp); end
        end
        bus_read(1'b0, c, oe);
        vec_cnt++; if (c !== 8'h50 || oe !== 1'b1) begin
            err_cnt++; $display("FAIL hello_status: got %h oe=%b want 50 oe=1", c, oe); end
    endtask

    task automatic test_data_read;
        logic [7:0] c;
        logic oe;
        cmd(CMD_SET_L0);
        bus_read(1'b1, c, oe);
        vec_cnt++; if (c !== "H" || oe !== 1'b1) begin err_cnt++; $display("FAIL dread_val: got %h oe=%b want 48 oe=1", c, oe); end
        vec_cnt++; if (ac !== 7'h01) begin err_cnt++; $display("FAIL dread_step: got %h want 01", ac); end
        bus_read(1'b0, c, oe);
        vec_cnt++; if (c !== 8'h01) begin err_cnt++; $display("FAIL dread_status: got %h want 01", c); end
        vec_cnt++; if (bus_if.O_LCD_OE !== 1'b0 || bus_if.O_LCD_DATA !== 8'h00) begin
            err_cnt++; $display("FAIL dread_release: got oe=%b data=%h want 0/00", bus_if.O_LCD_OE, bus_if.O_LCD_DATA); end
        cmd(8'hA0);
        bus_read(1'b1, c, oe);
        vec_cnt++; if (c !== 8'h20) begin err_cnt++; $display("FAIL dread_unmapped: got %h want 20", c); end
        vec_cnt++; if (ac !== 7'h21) begin err_cnt++; $display("FAIL dread_unmapped_step: got %h want 21", ac); end
    endtask

    task automatic test_busy_viol;
        logic [7:0] c;
        int v0;
        cmd(8'h85);
        v0 = viol_cnt;
        bus_write(1'b1, "A");
        tick(10);
        bus_write(1'b1, "B");
        wait_idle("viol");
        tick(2);
        vec_cnt++; if (viol_cnt !== v0 + 1) begin err_cnt++; $display("FAIL viol_pulse: got %0d want %0d", viol_cnt - v0, 1); end
        rd_cell(5, c);
        vec_cnt++; if (c !== "A") begin err_cnt++; $display("FAIL viol_cell5: got %h want 41", c); end
        rd_cell(6, c);
        vec_cnt++; if (c !== "W") begin err_cnt++; $display("FAIL viol_cell6: got %h want 57", c); end
        vec_cnt++; if (ac !== 7'h06) begin err_cnt++; $display("FAIL viol_ac: got %h want 06", ac); end
    endtask

    task automatic test_wrap;
        logic [7:0] c;
        cmd(8'h04);
        cmd(CMD_SET_L1);
        wdat("x");
        vec_cnt++; if (ac !== 7'h27) begin err_cnt++; $display("FAIL wrap_dec_40: got %h want 27", ac); end
        rd_cell(16, c);
        vec_cnt++; if (c !== "x") begin err_cnt++; $display("FAIL wrap_cell16: got %h want 78", c); end
        cmd(8'hA7);
        cmd(CMD_ENTRY_INC);
        wdat("y");
        vec_cnt++; if (ac !== 7'h40) begin err_cnt++; $display("FAIL wrap_inc_27: got %h want 40", ac); end
        cmd(8'hE7);
        wdat("z");
        vec_cnt++; if (ac !== 7'h00) begin err_cnt++; $display("FAIL wrap_inc_67: got %h want 00", ac); end
        cmd(8'h04);
        cmd(CMD_SET_L0);
        wdat("w");
        vec_cnt++; if (ac !== 7'h67) begin err_cnt++; $display("FAIL wrap_dec_00: got %h want 67", ac); end
        rd_cell(0, c);
        vec_cnt++; if (c !== "w") begin err_cnt++; $display("FAIL wrap_cell0: got %h want 77", c); end
        cmd(CMD_ENTRY_INC);
    endtask

    task automatic test_cmds;
        cmd(8'h83);
        cmd(8'h14);
        vec_cnt++; if (ac !== 7'h04) begin err_cnt++; $display("FAIL cmd_right: got %h want 04", ac); end
        cmd(8'h10);
        vec_cnt++; if (ac !== 7'h03) begin err_cnt++; $display("FAIL cmd_left: got %h want 03", ac); end
        cmd(8'h18);
        vec_cnt++; if (ac !== 7'h03) begin err_cnt++; $display("FAIL cmd_shift: got %h want 03", ac); end
        cmd(8'h0A);
        vec_cnt++; if (disp !== 3'b010) begin err_cnt++; $display("FAIL cmd_disp: got %b want 010", disp); end
        cmd(8'h02);
        vec_cnt++; if (ac !== 7'h00) begin err_cnt++; $display("FAIL cmd_home: got %h want 00", ac); end
        cmd(CMD_DISP_ON);
    endtask

    task automatic test_reset_mid_clear;
        logic [7:0] c;
        int n;
        rd_cell(15, c);
        vec_cnt++; if (c !== "4") begin err_cnt++; $display("FAIL rclr_pre_cell15: got %h want 34", c); end
        bus_write(1'b0, CMD_CLEAR);
        n = 0;
        while (!(dbg.state === LCD_CLEAR && dbg.clr_idx === 5'd10) && n < 60) begin tick(1); n++; end
        vec_cnt++; if (dbg.clr_idx !== 5'd10) begin err_cnt++; $display("FAIL rclr_reach10: got %0d want 10", dbg.clr_idx); end
        I_RSTF = 1'b0;
        tick(1);
        I_RSTF = 1'b1;
        vec_cnt++; if (dbg.state !== LCD_IDLE) begin err_cnt++; $display("FAIL rclr_state: got %0d want 0", dbg.state); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rclr_busy: got %b want 0", busy); end
        for (int i = 0; i < 32; i++) begin
            rd_cell(i, c);
            vec_cnt++; if (c !== 8'h20) begin err_cnt++; $display("FAIL rclr_cell%0d: got %h want 20", i, c); end
        end
        tick(2);
    endtask

    task automatic test_clear_status;
        logic [7:0] c;
        logic oe;
        cmd(8'h8A);
        bus_write(1'b0, CMD_CLEAR);
        tick(6);
        bus_read(1'b0, c, oe);
        vec_cnt++; if (c !== 8'h8A) begin err_cnt++; $display("FAIL clr_status_busy: got %h want 8a", c); end
        tick(CLR_CYC + 5);
        bus_read(1'b0, c, oe);
        vec_cnt++; if (c !== 8'h00 || oe !== 1'b1) begin
            err_cnt++; $display("FAIL clr_status_done: got %h oe=%b want 00 oe=1", c, oe); end
    endtask

    // sequence and report
    initial begin
        I_RSTF = 1'b0;
        rd_addr = 5'd0;
        bus_if.I_LCD_EN = 1'b0; bus_if.I_LCD_RS = 1'b0;
        bus_if.I_LCD_RWF = 1'b0; bus_if.I_LCD_DATA = 8'h00;
        test_reset();
        test_init();
        test_hello();
        test_data_read();
        test_busy_viol();
        test_wrap();
        test_cmds();
        test_reset_mid_clear();
        test_clear_status();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
